idct_block_buffer: RTL and testbench
====================================

# idct_block_buffer

Output stage of the 8x8 inverse-DCT datapath, directly downstream of the DCT loop controller and its MAC accumulator. On each controller `ready` pulse it captures the finished accumulator value for pixel (x, y), then rounds, offsets and saturates it to a pixel. It writes the result into one of two 64-entry ping-pong banks. A full bank is streamed out in raster order over a valid/ack handshake while the other bank fills, so the controller never waits on the consumer except on overrun.

## Interface
- `DATA_W`, 16: signed accumulator width of `acc_in`.
- `PIX_W`, 8: unsigned output pixel width.
- `SHIFT`, 3: arithmetic right shift applied after rounding; must be ≥1.
- `OFFSET`, 128: level offset added after the shift.

- `clk`  in  1  clock. All state is updated on the posedge, mid-period of the controller's negedge-updated outputs.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `ready_in`  in  1  one-cycle capture strobe from the controller.
- `x_in`  in  3  pixel column of the current result.
- `y_in`  in  3  pixel row of the current result.
- `acc_in`  in  DATA_W  signed MAC result. Stable whenever `ready_in`=1.
- `out_ack`  in  1  consumer accepts the current pixel.
- `pix_out`  out  PIX_W  pixel data.
- `pix_valid`  out  1  `pix_out`, `pix_x`, `pix_y` are valid.
- `pix_x`, `pix_y`  out  3 each  coordinates of `pix_out`.
- `blk_done`  out  1  one-cycle pulse after the 64th pixel of a block is accepted.
- `overrun`  out  1  sticky. A capture was dropped because the target bank was full.
- `sat_seen`  out  1  sticky. At least one captured value was clipped.

## Operation
- Conversion on capture, computed in DATA_W+2 signed bits:
  - t = (acc_in + 2^(SHIFT-1)) >>> SHIFT, then t + OFFSET.
  - Result clipped to [0, 2^PIX_W−1].
  - Any clipping sets `sat_seen`.
- Write side:
  - Write address = {y_in, x_in} (y*8+x) in bank `wr_bank`.
  - The capture is accepted only if `full[wr_bank]`=0. Otherwise the write is dropped and `overrun` is set.
  - An accepted write to address 63 sets `full[wr_bank]` and toggles `wr_bank`.
  - Writes to other addresses only store data; duplicate addresses overwrite.
- Read side:
  - Idle until `full[rd_bank]`=1, then streams addresses 0..63 of `rd_bank`.
  - `pix_valid` is held high with stable data until `out_ack` is sampled high.
  - On valid&ack: the read address increments, and the next pixel is presented on the following cycle (back-to-back streaming at 1 pixel/cycle when `out_ack` is held high).
  - On acceptance of address 63: clear `full[rd_bank]`, toggle `rd_bank`, pulse `blk_done`, return to idle or immediately start the other bank if it is full.
- Read states: IDLE → STREAM → (last ack) → IDLE or STREAM.
- `out_ack` while `pix_valid`=0 is ignored.
- Same-cycle write to a bank and release of that bank: full-flag checks use pre-edge state, so the write is dropped and `overrun` is set.
- Write and read on different banks in the same cycle proceed independently.

## Timing
- Reset values: `pix_out`=0, `pix_valid`=0, `pix_x`=`pix_y`=0, `blk_done`=0, `overrun`=0, `sat_seen`=0. Also `wr_bank`=`rd_bank`=0, both full flags=0, read address=0.
- Bank contents are not cleared by reset.
- Capture latency: data is written at the posedge where `ready_in`=1.
- A bank filled at posedge N gives `pix_valid`=1 with address 0 after posedge N+1, if the read side is idle.
- After the last ack at posedge K, `blk_done`=1 for the cycle following K. If the other bank is full, `pix_valid` stays high with its address 0 from K+1.
- Asynchronous reset mid-stream or mid-fill aborts immediately. Partial blocks are discarded.

## Test plan
- Single block, `out_ack` held at 1:
  - 64 captures, raster order, acc_in = 8*(y*8+x) − 256.
  - Required: 64 pixels in order, pix = (y*8+x) − 32 + 128 = 96..159.
  - `blk_done` pulses once; `overrun`=0; `sat_seen`=0.
- Rounding/saturation at defaults:
  - acc_in = 20 → pix 131.
  - acc_in = 1100 → 255, `sat_seen`=1.
  - acc_in = −1100 → 0.
  - acc_in = −1 → 128.
- Backpressure: `out_ack` high every third cycle. Each pixel stays stable until acked; no pixel is repeated or skipped.
- Ping-pong:
  - Fill bank 0, then fill bank 1 while bank 0 streams with slow acks.
  - Then 1 further capture while both banks are full.
  - Required: that capture is dropped, `overrun`=1; both blocks are output intact and in order; two `blk_done` pulses.
- Same-cycle release/write: the last ack of bank 0 coincides with the capture of (0,0) into bank 0. Required: write dropped, `overrun`=1, `rd_bank`=1.
- Reset after 30 pixels are streamed: all outputs return to their reset values. A new full block then streams from address 0 of bank 0.

Source files
------------

// File: rtl/idct_block_buffer_if.sv
// idct_block_buffer_if: capture strobe/data from the loop controller and the pixel valid/ack stream
interface idct_block_buffer_if #(
    parameter int DATA_W = 16,
    parameter int PIX_W  = 8
);
    logic                     ready_in;
    logic [2:0]               x_in;
    logic [2:0]               y_in;
    logic signed [DATA_W-1:0] acc_in;
    logic                     out_ack;
    logic [PIX_W-1:0]         pix_out;
    logic                     pix_valid;
    logic [2:0]               pix_x;
    logic [2:0]               pix_y;
    logic                     blk_done;
    logic                     overrun;
    logic                     sat_seen;

    modport master (
        output ready_in, x_in, y_in, acc_in, out_ack,
        input  pix_out, pix_valid, pix_x, pix_y, blk_done, overrun, sat_seen
    );
    modport slave (
        input  ready_in, x_in, y_in, acc_in, out_ack,
        output pix_out, pix_valid, pix_x, pix_y, blk_done, overrun, sat_seen
    );
endinterface

// File: rtl/idct_block_buffer.sv
// idct_block_buffer: rounds/offsets/saturates IDCT results into ping-pong 8x8 banks streamed out in raster order
module idct_block_buffer #(
    parameter int DATA_W = 16,
    parameter int PIX_W  = 8,
    parameter int SHIFT  = 3,
    parameter int OFFSET = 128
) (
    input logic                clk,
    input logic                rst_in,
    idct_block_buffer_if.slave bus
);
    localparam int CW = DATA_W + 2;
    typedef enum logic {IDLE, STREAM} state_t;
    state_t               state_q, state_d;
    logic [PIX_W-1:0]     mem_q [128];
    logic [PIX_W-1:0]     pix_q, pix_d, pix_cv;
    logic [5:0]           rd_addr_q, rd_addr_d, wr_addr;
    logic [1:0]           full_q, full_d;
    logic                 rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d;
    logic                 done_q, done_d, ovr_q, ovr_d, sat_q, sat_d;
    logic signed [CW-1:0] rnd, sh, lvl;
    logic                 lo, hi, wr_ok, take;

    always_comb begin
        rnd    = {{2{bus.acc_in[DATA_W-1]}}, bus.acc_in} + CW'(1 << (SHIFT - 1));
        sh     = rnd >>> SHIFT;
        lvl    = sh + CW'(OFFSET);
        lo     = lvl[CW-1];
        hi     = !lo && |lvl[CW-2:PIX_W];
        pix_cv = lo ? '0 : hi ? '1 : lvl[PIX_W-1:0];
    end

    assign wr_addr = {bus.y_in, bus.x_in};
    assign wr_ok   = bus.ready_in && !full_q[wr_bank_q];
    assign take    = state_q == STREAM && bus.out_ack;

    // Full flags are checked pre-edge, so a write into a bank being released this cycle is dropped
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        pix_d     = pix_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q | (bus.ready_in & ~wr_ok);
        sat_d     = sat_q | (wr_ok & (lo | hi));
        if (state_q == IDLE) begin
            if (full_q[rd_bank_q]) begin
                state_d = STREAM;
                pix_d   = mem_q[{rd_bank_q, 6'd0}];
            end
        end else if (take) begin
            if (rd_addr_q == 6'd63) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_addr_d         = 6'd0;
                done_d            = 1'b1;
                state_d           = full_q[~rd_bank_q] ? STREAM : IDLE;
                pix_d             = full_q[~rd_bank_q] ? mem_q[{~rd_bank_q, 6'd0}] : pix_q;
            end else begin
                rd_addr_d = rd_addr_q + 6'd1;
                pix_d     = mem_q[{rd_bank_q, rd_addr_q + 6'd1}];
            end
        end
        if (wr_ok && wr_addr == 6'd63) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rd_bank_q <= 1'b0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            pix_q     <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_bank_q <= rd_bank_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            pix_q     <= pix_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            sat_q     <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in && wr_ok)
            mem_q[{wr_bank_q, wr_addr}] <= pix_cv;
    end

    assign bus.pix_out   = pix_q;
    assign bus.pix_valid = state_q == STREAM;
    assign bus.pix_x     = rd_addr_q[2:0];
    assign bus.pix_y     = rd_addr_q[5:3];
    assign bus.blk_done  = done_q;
    assign bus.overrun   = ovr_q;
    assign bus.sat_seen  = sat_q;
endmodule

// File: tb/tb_idct_block_buffer.sv
// tb_idct_block_buffer: directed ping-pong, backpressure, saturation and reset scenarios with an expected-pixel queue
module tb_idct_block_buffer;
    logic clk = 1'b0;
    logic rst_in = 1'b0;
    int   n_chk = 0, n_pass = 0, n_done = 0, cyc = 0;
    int   exp_q[$];

    idct_block_buffer_if #(.DATA_W(16), .PIX_W(8)) b();
    idct_block_buffer dut (.clk(clk), .rst_in(rst_in), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int pk(input int a, input int p);
        return a * 256 + p;
    endfunction

    function automatic bit ak(input int per);
        return per != 0 && cyc % per == 0;
    endfunction

    // Hand-derived stimulus and pixel values for each data pattern
    function automatic int acc_of(input int mode, input int k);
        if (mode == 0) return 8 * k - 256;
        if (mode == 1) return k == 0 ? 20 : k == 1 ? 1100 : k == 2 ? -1100 : k == 3 ? -1 : 0;
        if (mode == 2) return 8 * k;
        return -8 * k;
    endfunction

    function automatic int pix_of(input int mode, input int k);
        if (mode == 0) return 96 + k;
        if (mode == 1) return k == 0 ? 131 : k == 1 ? 255 : k == 2 ? 0 : 128;
        if (mode == 2) return 128 + k;
        return 128 - k;
    endfunction

    task automatic push(input int mode);
        for (int k = 0; k < 64; k++) exp_q.push_back(pk(k, pix_of(mode, k)));
    endtask

    task automatic step(input bit cap, input int a, input int acc, input bit ack);
        if (b.pix_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("extra_pix", int'({b.pix_y, b.pix_x, b.pix_out}), -1);
            else begin
                chk("pix", int'({b.pix_y, b.pix_x, b.pix_out}), exp_q[0]);
                if (ack) void'(exp_q.pop_front());
            end
        end
        if (b.blk_done === 1'b1) n_done++;
        b.ready_in = cap;
        b.x_in     = a[2:0];
        b.y_in     = a[5:3];
        b.acc_in   = acc[15:0];
        b.out_ack  = ack;
        cyc++;
        @(negedge clk);
    endtask

    task automatic fill(input int mode, input int per);
        for (int k = 0; k < 64; k++) begin
            step(1'b1, k, acc_of(mode, k), ak(per));
            if (mode == 1 && k < 2) chk("sat_step", int'(b.sat_seen), k);
        end
        b.ready_in = 1'b0;
    endtask

    task automatic drain(input int per, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b0, 0, 0, ak(per));
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1);
    endtask

    task automatic rst_chk();
        chk("rst_pix", int'(b.pix_out), 0);
        chk("rst_valid", int'(b.pix_valid), 0);
        chk("rst_x", int'(b.pix_x), 0);
        chk("rst_y", int'(b.pix_y), 0);
        chk("rst_done", int'(b.blk_done), 0);
        chk("rst_overrun", int'(b.overrun), 0);
        chk("rst_sat", int'(b.sat_seen), 0);
    endtask

    initial begin
        b.ready_in = 1'b0;
        b.x_in     = '0;
        b.y_in     = '0;
        b.acc_in   = '0;
        b.out_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst_chk();
        rst_in = 1'b1;
        @(negedge clk);

        // single block, ack held high
        push(0);
        fill(0, 1);
        chk("lat_fill", int'(b.pix_valid), 0);
        step(1'b0, 0, 0, 1'b1);
        chk("lat_valid", int'(b.pix_valid), 1);
        drain(1, 80);
        idle(3);
        chk("blk1_done", n_done, 1);
        chk("blk1_overrun", int'(b.overrun), 0);
        chk("blk1_sat", int'(b.sat_seen), 0);

        // rounding/saturation values streamed with ack every third cycle
        n_done = 0;
        push(1);
        fill(1, 0);
        drain(3, 250);
        idle(3);
        chk("bp_done", n_done, 1);
        chk("bp_sat", int'(b.sat_seen), 1);

        // ping-pong with both banks full, then one extra capture
        n_done = 0;
        push(2);
        push(3);
        fill(2, 0);
        fill(3, 3);
        chk("pp_overrun_pre", int'(b.overrun), 0);
        step(1'b1, 0, 1100, ak(3));
        chk("pp_overrun", int'(b.overrun), 1);
        drain(3, 500);
        idle(3);
        chk("pp_done", n_done, 2);

        // asynchronous reset after 30 pixels of a stream
        push(2);
        fill(2, 0);
        repeat (31) step(1'b0, 0, 0, 1'b1);
        chk("pre_rst_valid", int'(b.pix_valid), 1);
        #2 rst_in = 1'b0;
        #1 rst_chk();
        exp_q.delete();
        @(negedge clk);
        rst_in = 1'b1;
        n_done = 0;
        push(3);
        fill(3, 0);
        drain(1, 80);
        idle(3);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_rdbank", int'(dut.rd_bank_q), 1);

        // last ack of bank 0 coincides with a capture of (0,0) into bank 0
        @(negedge clk) rst_in = 1'b0;
        @(negedge clk) rst_in = 1'b1;
        n_done = 0;
        push(2);
        push(3);
        fill(2, 0);
        fill(3, 0);
        for (int n = 0; n < 200 && exp_q.size() > 65; n++) step(1'b0, 0, 0, 1'b1);
        chk("sc_reach_last", exp_q.size(), 65);
        chk("sc_overrun_pre", int'(b.overrun), 0);
        step(1'b1, 0, 1100, 1'b1);
        chk("sc_overrun", int'(b.overrun), 1);
        chk("sc_rdbank", int'(dut.rd_bank_q), 1);
        chk("sc_valid", int'(b.pix_valid), 1);
        drain(1, 100);
        idle(3);
        chk("sc_done", n_done, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
